// File: rtl/mchan_rr_arbiter_ipa_pkg.sv
// Shared types and pointer arithmetic for the MCHAN round-robin arbiter family.
// The pointer wraps at the channel count, so non-power-of-2 trees never reach an unused slot.
package mchan_arb_pkg;

  typedef enum logic {RR_INC, RR_WINNER} rr_mode_e;
  typedef enum logic {ARB, LOCKED} rr_state_e;

  function automatic int rr_wrap_inc(input int value, input int n_ch);
    return (value == n_ch - 1) ? 0 : value + 1;
  endfunction

endpackage

// File: rtl/mchan_rr_arbiter_ipa_if.sv
// Request/grant bundle between requesters (master) and the round-robin arbiter (slave).
interface mchan_rr_arbiter_ipa_if #(
  parameter int N_CH  = 4,
  parameter int PTR_W = $clog2(N_CH)
);

  logic [N_CH-1:0]  req_i;
  logic             lock_i;
  logic             ready_i;
  logic             valid_o;
  logic [N_CH-1:0]  gnt_o;
  logic [PTR_W-1:0] gnt_idx_o;
  logic [PTR_W-1:0] rr_flag_o;
  logic             locked_o;

  modport master (
    output req_i, lock_i, ready_i,
    input  valid_o, gnt_o, gnt_idx_o, rr_flag_o, locked_o
  );

  modport slave (
    input  req_i, lock_i, ready_i,
    output valid_o, gnt_o, gnt_idx_o, rr_flag_o, locked_o
  );

endinterface

// File: rtl/mchan_rr_ff1_ipa.sv
// Rotating find-first-one: index of the first set request at or above ptr_i, wrapping at N_CH.
// Purely combinational so other arbitration tree levels can reuse it.
module mchan_rr_ff1_ipa #(
  parameter int N_CH = 4,
  localparam int PTR_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [PTR_W-1:0] idx_o,
  output logic             found_o
);

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    int w_pos;
    found_o = 1'b0;
    idx_o   = '0;
    w_pos   = 0;
    for (int i = 0; i < N_CH; i++) begin
      w_pos = int'(ptr_i) + i;
      // ptr_i is always below N_CH, so a single subtraction replaces a modulo
      if (w_pos >= N_CH) w_pos = w_pos - N_CH;
      if (!found_o && req_i[PTR_W'(w_pos)]) begin
        found_o = 1'b1;
        idx_o   = PTR_W'(w_pos);
      end
    end
  end

endmodule

// File: rtl/mchan_rr_arbiter_ipa.sv
// N-channel round-robin arbiter with a rotating priority pointer and a multi-beat burst lock.
// State only moves on an accepted beat, so an idle arbiter never toggles.
module mchan_rr_arbiter_ipa
  import mchan_arb_pkg::*;
#(
  parameter int       N_CH = 4,
  parameter rr_mode_e MODE = RR_INC
) (
  input logic                  clk,
  input logic                  rst_n,
  mchan_rr_arbiter_ipa_if.slave bus
);

  localparam int PTR_W = $clog2(N_CH);

  rr_state_e        r_state;
  rr_state_e        w_state_nxt;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ptr_nxt;
  logic [PTR_W-1:0] r_lock_idx;
  logic [PTR_W-1:0] w_lock_idx_nxt;
  logic [PTR_W-1:0] w_ff1_idx;
  logic             w_ff1_found;
  logic [PTR_W-1:0] w_winner;
  logic [PTR_W-1:0] w_ptr_upd;
  logic             w_valid;
  logic             w_accept;

  mchan_rr_ff1_ipa #(.N_CH(N_CH)) u_ff1 (
    .req_i   (bus.req_i),
    .ptr_i   (r_ptr),
    .idx_o   (w_ff1_idx),
    .found_o (w_ff1_found)
  );

  // A locked burst pins the winner even if that channel drops its request.
  always_comb begin
    w_winner = (r_state == LOCKED) ? r_lock_idx : w_ff1_idx;
    w_valid  = (r_state == LOCKED) ? bus.req_i[r_lock_idx] : w_ff1_found;
    w_accept = w_valid & bus.ready_i;
  end

  always_comb begin
    if (MODE == RR_INC) w_ptr_upd = PTR_W'(rr_wrap_inc(int'(r_ptr), N_CH));
    else                w_ptr_upd = PTR_W'(rr_wrap_inc(int'(w_winner), N_CH));
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_lock_idx_nxt = r_lock_idx;
    if (w_accept) begin
      unique case (r_state)
        ARB: begin
          if (bus.lock_i) begin
            w_state_nxt    = LOCKED;
            w_lock_idx_nxt = w_winner;
          end else begin
            w_ptr_nxt = w_ptr_upd;
          end
        end
        LOCKED: begin
          if (!bus.lock_i) begin
            w_state_nxt = ARB;
            w_ptr_nxt   = w_ptr_upd;
          end
        end
        default: w_state_nxt = ARB;
      endcase
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARB;
      r_ptr      <= '0;
      r_lock_idx <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_lock_idx <= w_lock_idx_nxt;
    end
  end

  always_comb begin
    bus.valid_o   = w_valid;
    bus.gnt_o     = w_valid ? (N_CH'(1) << w_winner) : '0;
    bus.gnt_idx_o = w_valid ? w_winner : '0;
    bus.rr_flag_o = r_ptr;
    bus.locked_o  = (r_state == LOCKED);
  end

`ifndef SYNTHESIS
  a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(bus.gnt_o));

  a_ptr_range: assert property (@(posedge clk) disable iff (!rst_n)
    int'(r_ptr) < N_CH);

  a_arb_grant_req: assert property (@(posedge clk) disable iff (!rst_n)
    (r_state == ARB && bus.valid_o) |-> bus.req_i[bus.gnt_idx_o]);
`endif

endmodule

// File: tb/tb_mchan_rr_arbiter_ipa.sv
// Self-checking bench: directed vector table, corner sequences and randomized traffic
// against a queue-free reference model for three arbiter configurations.
module tb_mchan_rr_arbiter_ipa;
  import mchan_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mchan_rr_arbiter_ipa_if #(.N_CH(4)) ifa ();
  mchan_rr_arbiter_ipa_if #(.N_CH(3)) ifb ();
  mchan_rr_arbiter_ipa_if #(.N_CH(4)) ifc ();

  mchan_rr_arbiter_ipa #(.N_CH(4), .MODE(RR_INC))    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  mchan_rr_arbiter_ipa #(.N_CH(3), .MODE(RR_INC))    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  mchan_rr_arbiter_ipa #(.N_CH(4), .MODE(RR_WINNER)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic [31:0] req, input logic lock, input logic ready);
    case (k)
      0: begin ifa.req_i = req[3:0]; ifa.lock_i = lock; ifa.ready_i = ready; end
      1: begin ifb.req_i = req[2:0]; ifb.lock_i = lock; ifb.ready_i = ready; end
      default: begin ifc.req_i = req[3:0]; ifc.lock_i = lock; ifc.ready_i = ready; end
    endcase
  endtask

  task automatic get_out(input int k, output logic v, output logic [31:0] gnt,
                         output logic [31:0] idx, output logic [31:0] flag, output logic lk);
    case (k)
      0: begin v = ifa.valid_o; gnt = 32'(ifa.gnt_o); idx = 32'(ifa.gnt_idx_o);
               flag = 32'(ifa.rr_flag_o); lk = ifa.locked_o; end
      1: begin v = ifb.valid_o; gnt = 32'(ifb.gnt_o); idx = 32'(ifb.gnt_idx_o);
               flag = 32'(ifb.rr_flag_o); lk = ifb.locked_o; end
      default: begin v = ifc.valid_o; gnt = 32'(ifc.gnt_o); idx = 32'(ifc.gnt_idx_o);
               flag = 32'(ifc.rr_flag_o); lk = ifc.locked_o; end
    endcase
  endtask

  task automatic do_reset();
    for (int k = 0; k < 3; k++) drive(k, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Reference model: priority pointer, lock flag and locked channel per instance.
  int nch[3]  = '{4, 3, 4};
  bit mwin[3] = '{1'b0, 1'b0, 1'b1};
  int m_ptr[3];
  int m_lidx[3];
  bit m_lk[3];

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_ptr[k] = 0; m_lidx[k] = 0; m_lk[k] = 1'b0;
    end
  endtask

  function automatic void model_eval(input int k, input logic [31:0] req, output bit v, output int w);
    v = 1'b0;
    w = 0;
    if (m_lk[k]) begin
      w = m_lidx[k];
      v = req[w];
    end else begin
      for (int off = 0; off < nch[k]; off++) begin
        int c;
        c = (m_ptr[k] + off) % nch[k];
        if (req[c]) begin
          v = 1'b1; w = c; break;
        end
      end
    end
  endfunction

  task automatic model_step(input int k, input logic [31:0] req, input logic lock, input logic ready);
    bit v;
    int w;
    model_eval(k, req, v, w);
    if (v && ready) begin
      if (lock) begin
        if (!m_lk[k]) m_lidx[k] = w;
        m_lk[k] = 1'b1;
      end else begin
        m_lk[k]  = 1'b0;
        m_ptr[k] = mwin[k] ? (w + 1) % nch[k] : (m_ptr[k] + 1) % nch[k];
      end
    end
  endtask

  task automatic check_model(input int k, input logic [31:0] req);
    bit v;
    int w;
    logic a_v, a_lk;
    logic [31:0] a_gnt, a_idx, a_flag;
    model_eval(k, req, v, w);
    get_out(k, a_v, a_gnt, a_idx, a_flag, a_lk);
    check($sformatf("rnd%0d valid", k), 32'(a_v), 32'(v));
    check($sformatf("rnd%0d idx", k), a_idx, v ? 32'(w) : 32'd0);
    check($sformatf("rnd%0d gnt", k), a_gnt, v ? (32'd1 << w) : 32'd0);
    check($sformatf("rnd%0d flag", k), a_flag, 32'(m_ptr[k]));
    check($sformatf("rnd%0d locked", k), 32'(a_lk), 32'(m_lk[k]));
  endtask

  typedef struct {
    logic [3:0] req;
    logic       lock;
    logic       ready;
    logic       e_valid;
    logic [1:0] e_idx;
    logic [1:0] e_flag;
    logic       e_locked;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [3:0] req, logic lock, logic ready,
                              logic ev, logic [1:0] ei, logic [1:0] ef, logic el);
    vec_t t;
    t.req = req; t.lock = lock; t.ready = ready;
    t.e_valid = ev; t.e_idx = ei; t.e_flag = ef; t.e_locked = el;
    return t;
  endfunction

  initial begin
    logic        a_v, a_lk;
    logic [31:0] a_gnt, a_idx, a_flag;

    // Directed vectors for the 4-channel RR_INC instance.
    for (int i = 0; i < 8; i++) tbl.push_back(mk(4'hF, 1'b0, 1'b1, 1'b1, 2'(i), 2'(i), 1'b0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(4'hF, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0));
    tbl.push_back(mk(4'hF, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 1'b0));
    tbl.push_back(mk(4'hF, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 1'b1));
    tbl.push_back(mk(4'hE, 1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1));
    tbl.push_back(mk(4'hF, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1));
    tbl.push_back(mk(4'hF, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 1'b1));
    tbl.push_back(mk(4'hF, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 1'b1));
    tbl.push_back(mk(4'hF, 1'b0, 1'b0, 1'b1, 2'd1, 2'd1, 1'b0));
    tbl.push_back(mk(4'h0, 1'b1, 1'b1, 1'b0, 2'd0, 2'd1, 1'b0));
    tbl.push_back(mk(4'h4, 1'b0, 1'b0, 1'b1, 2'd2, 2'd1, 1'b0));

    do_reset();
    #2;
    get_out(0, a_v, a_gnt, a_idx, a_flag, a_lk);
    check("reset flag", a_flag, 32'd0);
    check("reset locked", 32'(a_lk), 32'd0);
    check("reset gnt", a_gnt, 32'd0);
    check("reset valid", 32'(a_v), 32'd0);
    tick();

    foreach (tbl[i]) begin
      drive(0, 32'(tbl[i].req), tbl[i].lock, tbl[i].ready);
      #2;
      get_out(0, a_v, a_gnt, a_idx, a_flag, a_lk);
      check($sformatf("vec%0d valid", i), 32'(a_v), 32'(tbl[i].e_valid));
      check($sformatf("vec%0d idx", i), a_idx, 32'(tbl[i].e_idx));
      check($sformatf("vec%0d gnt", i), a_gnt,
            tbl[i].e_valid ? (32'd1 << tbl[i].e_idx) : 32'd0);
      check($sformatf("vec%0d flag", i), a_flag, 32'(tbl[i].e_flag));
      check($sformatf("vec%0d locked", i), 32'(a_lk), 32'(tbl[i].e_locked));
      tick();
    end

    // Three channels: pointer wraps 2 -> 0 and never shows 3.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'h7, 1'b0, 1'b1);
      #2;
      get_out(1, a_v, a_gnt, a_idx, a_flag, a_lk);
      check($sformatf("n3 idx%0d", i), a_idx, 32'(i % 3));
      check($sformatf("n3 flag%0d", i), a_flag, 32'(i % 3));
      tick();
    end
    get_out(1, a_v, a_gnt, a_idx, a_flag, a_lk);
    check("n3 flag wrap", a_flag, 32'd0);

    // RR_WINNER: pointer follows winner+1, wrapping at N_CH.
    do_reset();
    drive(2, 32'h4, 1'b0, 1'b1);
    #2;
    get_out(2, a_v, a_gnt, a_idx, a_flag, a_lk);
    check("win idx2", a_idx, 32'd2);
    tick();
    get_out(2, a_v, a_gnt, a_idx, a_flag, a_lk);
    check("win flag3", a_flag, 32'd3);
    drive(2, 32'h9, 1'b0, 1'b1);
    #2;
    get_out(2, a_v, a_gnt, a_idx, a_flag, a_lk);
    check("win idx3", a_idx, 32'd3);
    tick();
    get_out(2, a_v, a_gnt, a_idx, a_flag, a_lk);
    check("win flag0", a_flag, 32'd0);

    // Async reset while locked with pointer at 2.
    do_reset();
    drive(0, 32'hF, 1'b0, 1'b1);
    tick();
    tick();
    drive(0, 32'hF, 1'b1, 1'b1);
    tick();
    drive(0, 32'hF, 1'b1, 1'b0);
    #2;
    get_out(0, a_v, a_gnt, a_idx, a_flag, a_lk);
    check("pre-rst locked", 32'(a_lk), 32'd1);
    check("pre-rst flag", a_flag, 32'd2);
    check("pre-rst idx", a_idx, 32'd2);
    rst_n = 1'b0;
    #1;
    get_out(0, a_v, a_gnt, a_idx, a_flag, a_lk);
    check("async rst flag", a_flag, 32'd0);
    check("async rst locked", 32'(a_lk), 32'd0);
    tick();
    rst_n = 1'b1;
    drive(0, 32'h6, 1'b0, 1'b0);
    #2;
    get_out(0, a_v, a_gnt, a_idx, a_flag, a_lk);
    check("post-rst idx", a_idx, 32'd1);
    tick();

    // Randomized traffic on all three instances against the model.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic [31:0] rq[3];
      logic        lk_in[3];
      logic        rdy[3];
      for (int k = 0; k < 3; k++) begin
        rq[k]    = $urandom & ((32'd1 << nch[k]) - 32'd1);
        lk_in[k] = ($urandom_range(0, 2) == 0);
        rdy[k]   = ($urandom_range(0, 3) != 0);
        drive(k, rq[k], lk_in[k], rdy[k]);
      end
      #2;
      for (int k = 0; k < 3; k++) check_model(k, rq[k]);
      @(posedge clk);
      for (int k = 0; k < 3; k++) model_step(k, rq[k], lk_in[k], rdy[k]);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mchan_rr_arbiter_ipa.md
Name: mchan_rr_arbiter_ipa

Overview:
- Parametrised N-channel round-robin arbiter for the MCHAN/log-interconnect arbitration trees; next generation of the single RR flag counter.
- Holds the rotating priority pointer, resolves a one-hot grant combinationally against it, and advances the pointer only on an accepted handshake (no toggling when idle, clock-gating friendly).
- Adds a non-power-of-2 channel count, a selectable pointer-update mode, and a burst lock that pins the grant to one channel across multiple beats.

Parameters:
- N_CH, 4, number of requesting channels; legal range 2..32.
- PTR_W, $clog2(N_CH), width of the pointer and index outputs; derived, do not override.
- MODE, RR_INC, pointer update policy (mchan_arb_pkg::rr_mode_e):
  - RR_INC: pointer+1 on each accept.
  - RR_WINNER: pointer set to winner+1 on each accept.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-low.
- req_i  in  N_CH  per-channel request.
- lock_i  in  1  sampled on accept; 1 = keep grant on the current winner for the next beat.
- ready_i  in  1  downstream accepts the current beat.
- valid_o  out  1  a granted request is present.
- gnt_o  out  N_CH  one-hot grant, all zeros when valid_o=0.
- gnt_idx_o  out  PTR_W  binary index of the granted channel, 0 when valid_o=0.
- rr_flag_o  out  PTR_W  current priority pointer (registered).
- locked_o  out  1  arbiter is in the LOCKED state (registered).

Behaviour:
- Reset (async, rst_n=0): ptr=0, state=ARB, lock_idx=0. Outputs: rr_flag_o=0, locked_o=0. Combinational outputs follow from these, so gnt_o=0 when req_i=0.
- Accept = valid_o & ready_i. All state changes happen only on accept; no update when req_i=0 or ready_i=0.
- State ARB:
  - Winner = first set req_i bit searching upward from ptr, wrapping N_CH-1 -> 0.
  - valid_o = |req_i. Grant is zero-latency (combinational from req_i and ptr).
- State LOCKED:
  - Winner = lock_idx unconditionally.
  - valid_o = req_i[lock_idx]. Other requests are ignored even if lock_idx drops its request.
- Transitions:
  - ARB -> LOCKED: on accept with lock_i=1; lock_idx <= winner; ptr unchanged.
  - ARB -> ARB: on accept with lock_i=0; ptr updated per MODE.
  - LOCKED -> LOCKED: on accept with lock_i=1.
  - LOCKED -> ARB: on accept with lock_i=0; ptr updated per MODE from winner=lock_idx.
- Pointer arithmetic is modulo N_CH, not 2^PTR_W:
  - RR_INC: ptr <= (ptr==N_CH-1) ? 0 : ptr+1.
  - RR_WINNER: ptr <= (winner==N_CH-1) ? 0 : winner+1.
- Pointer values >= N_CH are unreachable; an assertion flags them.
- Simultaneous events:
  - req_i changing in the accept cycle uses the pre-edge combinational winner.
  - lock_i is ignored in cycles with no accept.
- Invariants: gnt_o is $onehot0 and consistent with gnt_idx_o at all times; the grant is stable while valid_o & !ready_i only if req_i is stable (no stickiness in ARB).
- Reset asserted mid-burst: LOCKED is abandoned, ptr returns to 0, next grant is re-arbitrated.
- SVA (in the module, under translate_off): onehot0(gnt_o); ptr < N_CH; valid_o -> req_i[gnt_idx_o] in ARB.

Decomposition:
- Package mchan_arb_pkg: typedef enum logic {RR_INC, RR_WINNER} rr_mode_e; typedef enum logic {ARB, LOCKED} rr_state_e.
- Sub-module mchan_rr_ff1_ipa: combinational rotate-and-find-first-one from a pointer.
  - Parameter N_CH.
  - Ports: req_i, ptr_i, idx_o, found_o.
  - Reused by other tree levels.
- Top module contains the pointer register, state FSM, lock index register, and onehot decode.

Test Plan:
- N_CH=4, RR_INC, req_i=4'b1111, ready_i=1 for 8 cycles -> gnt_idx_o 0,1,2,3,0,1,2,3; rr_flag_o 0,1,2,3,0,...
- N_CH=3, RR_INC, req_i=3'b111, ready_i=1, 6 accepts -> rr_flag_o 0,1,2,0,1,2; never 3.
- N_CH=4, RR_WINNER, ptr=0, req_i=4'b0100 accepted -> gnt_idx_o=2, next rr_flag_o=3. Then req_i=4'b1001 -> gnt_idx_o=3, next rr_flag_o=0.
- N_CH=4, req_i=4'b1111, ready_i=0 for 5 cycles -> gnt_idx_o constant 0, rr_flag_o stays 0 (no update without accept).
- Lock: req_i=4'b1111, accept ch0 with lock_i=1, then 3 accepts with lock_i=1,1,0 -> gnt_idx_o=0 all 4 beats, locked_o=1 during beats 2-4. After the final accept, rr_flag_o=1 (RR_INC) and locked_o=0. While locked with req_i=4'b1110: valid_o=0, gnt_o=0.
- Async reset in LOCKED with rr_flag_o=2 -> immediately rr_flag_o=0, locked_o=0; after release with req_i=4'b0110 -> gnt_idx_o=1.
